// File: rtl/uart_rx_edge_bit_counter_p.sv
// ----------------------------------------------------------------------------
// uart_rx_edge_bit_counter_p
//
// Oversampling edge/bit counter for the UART receive path. Runs on the
// prescaled sampling clock. It counts sample edges inside each bit period and
// counts bits up to the frame length. It also decodes the mid-bit sample
// strobes, the bit-done pulse and the frame-done pulse used by the RX FSM, the
// data sampler and the deserializer.
//
// Parameters
//   PRESCALE_W  width of prescale / edge_count (max ratio 2^PRESCALE_W-1)
//   BIT_CNT_W   width of frame_bits / bit_count (max frame 2^BIT_CNT_W-1 bits)
//
// Ports
//   clk_based_on_prescale  in   oversampled clock, one rising edge per sample
//   asy_reset              in   asynchronous reset, active low
//   cnt_start              in   1-cycle pulse: latch config, clear counters
//   cnt_enable             in   count enable; low freezes counters
//   prescale   [PW-1:0]    in   samples per bit, latched on cnt_start (min 4)
//   frame_bits [BW-1:0]    in   bits per frame, latched on cnt_start (min 1)
//   rx_in                  in   synchronised RX line (resync build only)
//   edge_count [PW-1:0]    out  sample index within the current bit
//   bit_count  [BW-1:0]    out  index of the bit currently being sampled
//   sample_strobe [2:0]    out  one-hot strobes at edges M-1, M, M+1 (M=P/2)
//   bit_done               out  last edge of the current bit
//   frame_done             out  last edge of the last bit of the frame
//   busy                   out  counter is in the COUNT state
//
// Build option
//   UART_RX_RESYNC_EN  when defined, an RX transition seen early in a bit
//                      re-phases edge_count to 1. The default build ignores
//                      rx_in.
// ----------------------------------------------------------------------------
module uart_rx_edge_bit_counter_p #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic                  cnt_start,
    input  logic                  cnt_enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    input  logic                  rx_in,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic [2:0]            sample_strobe,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  busy
);

    // The minimum ratio of 4 must be representable, and so must the reset
    // ratio of 8.
    if (PRESCALE_W < 4) begin : g_bad_prescale_w
        $error("PRESCALE_W must be at least 4");
    end
    if (BIT_CNT_W < 1) begin : g_bad_bit_cnt_w
        $error("BIT_CNT_W must be at least 1");
    end

    localparam logic [PRESCALE_W-1:0] P_MIN   = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] P_RESET = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] E_ONE   = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  F_ONE   = BIT_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_q,  edge_d;
    logic [BIT_CNT_W-1:0]    bit_q,   bit_d;
    logic [PRESCALE_W-1:0]   p_q,     p_d;
    logic [BIT_CNT_W-1:0]    f_q,     f_d;

    logic [PRESCALE_W-1:0]   p_load;
    logic [BIT_CNT_W-1:0]    f_load;
    logic [PRESCALE_W-1:0]   p_last;
    logic [BIT_CNT_W-1:0]    f_last;
    logic [PRESCALE_W-1:0]   mid;
    logic                    active;
    logic                    last_edge;
    logic                    last_bit;
    logic                    resync;

    // ------------------------------------------------------------------------
    // Configuration clamp and derived compare values
    // ------------------------------------------------------------------------
    always_comb begin
        p_load = (prescale < P_MIN) ? P_MIN : prescale;
        f_load = (frame_bits == '0) ? F_ONE : frame_bits;
    end

    always_comb begin
        p_last    = p_q - E_ONE;
        f_last    = f_q - F_ONE;
        mid       = p_q >> 1;
        active    = (state_q == S_COUNT) && cnt_enable;
        last_edge = (edge_q == p_last);
        last_bit  = (bit_q == f_last);
    end

    // ------------------------------------------------------------------------
    // Optional re-phasing on an early RX transition
    // ------------------------------------------------------------------------
`ifdef UART_RX_RESYNC_EN
    logic rx_q, rx_d;

    always_comb begin
        rx_d = rx_in;
    end

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            rx_q <= 1'b1;
        end else begin
            rx_q <= rx_d;
        end
    end

    // Window is edges 1..P/4 of the current bit; last_edge can never fall in
    // it because P >= 4, so the wrap path always wins naturally.
    always_comb begin
        resync = active && (rx_in != rx_q) &&
                 (edge_q >= E_ONE) && (edge_q <= (p_q >> 2));
    end
`else
    logic unused_rx_in;

    always_comb begin
        unused_rx_in = rx_in;
        resync       = 1'b0;
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        p_d     = p_q;
        f_d     = f_q;

        if (cnt_start) begin
            // Restart wins over enable and frame end in every state.
            state_d = S_COUNT;
            edge_d  = '0;
            bit_d   = '0;
            p_d     = p_load;
            f_d     = f_load;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    edge_d = '0;
                    bit_d  = '0;
                end
                S_COUNT: begin
                    if (cnt_enable) begin
                        if (last_edge) begin
                            edge_d = '0;
                            if (last_bit) begin
                                // bit_count parks on the last bit index.
                                state_d = S_DONE;
                            end else begin
                                bit_d = bit_q + F_ONE;
                            end
                        end else if (resync) begin
                            edge_d = E_ONE;
                        end else begin
                            edge_d = edge_q + E_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!cnt_enable) begin
                        state_d = S_IDLE;
                        edge_d  = '0;
                        bit_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            state_q <= S_IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            p_q     <= P_RESET;
            f_q     <= F_ONE;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            f_q     <= f_d;
        end
    end

    // ------------------------------------------------------------------------
    // Decoded outputs (combinational from registered state)
    // ------------------------------------------------------------------------
    always_comb begin
        edge_count       = edge_q;
        bit_count        = bit_q;
        busy             = (state_q == S_COUNT);
        sample_strobe[0] = active && (edge_q == (mid - E_ONE));
        sample_strobe[1] = active && (edge_q == mid);
        sample_strobe[2] = active && (edge_q == (mid + E_ONE));
        bit_done         = active && last_edge;
        frame_done       = active && last_edge && last_bit;
    end

endmodule

// File: tb/tb_uart_rx_edge_bit_counter_p.sv
module tb_uart_rx_edge_bit_counter_p;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          asy_reset;
    logic          cnt_start;
    logic          cnt_enable;
    logic [PW-1:0] prescale;
    logic [BW-1:0] frame_bits;
    logic          rx_in;
    logic [PW-1:0] edge_count;
    logic [BW-1:0] bit_count;
    logic [2:0]    sample_strobe;
    logic          bit_done;
    logic          frame_done;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx_edge_bit_counter_p #(
        .PRESCALE_W (PW),
        .BIT_CNT_W  (BW)
    ) dut (
        .clk_based_on_prescale (clk),
        .asy_reset             (asy_reset),
        .cnt_start             (cnt_start),
        .cnt_enable            (cnt_enable),
        .prescale              (prescale),
        .frame_bits            (frame_bits),
        .rx_in                 (rx_in),
        .edge_count            (edge_count),
        .bit_count             (bit_count),
        .sample_strobe         (sample_strobe),
        .bit_done              (bit_done),
        .frame_done            (frame_done),
        .busy                  (busy)
    );

    typedef struct {
        int            tag;
        logic [PW-1:0] e;
        logic [BW-1:0] b;
        logic [2:0]    s;
        logic          bd;
        logic          fd;
        logic          bz;
    } exp_t;

    typedef struct {
        logic          st;
        logic          en;
        logic [PW-1:0] pre;
        logic [BW-1:0] fb;
        logic [PW-1:0] e;
        logic [BW-1:0] b;
        logic [2:0]    s;
        logic          bd;
        logic          fd;
        logic          bz;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_x;
    vec_t tbl[9];

    int n_cmp = 0;
    int n_bad = 0;
    int tag_ctr = 0;

    // Reference: after a start, m_j enabled edges have elapsed in the frame.
    int m_p = 8;
    int m_f = 1;
    int m_j = 0;
    bit m_idle = 1'b1;

    function automatic void chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
        end
    endfunction

    function automatic exp_t model_exp(input logic en);
        exp_t x;
        int   ed;
        int   m;
        x.tag = 0;
        x.e   = '0;
        x.b   = '0;
        x.s   = '0;
        x.bd  = 1'b0;
        x.fd  = 1'b0;
        x.bz  = 1'b0;
        if (m_idle) return x;
        if (m_j >= m_p * m_f) begin
            x.b = BW'(m_f - 1);
            return x;
        end
        ed   = m_j % m_p;
        m    = m_p / 2;
        x.e  = PW'(ed);
        x.b  = BW'(m_j / m_p);
        x.bz = 1'b1;
        if (en) begin
            x.s  = {ed == m + 1, ed == m, ed == m - 1};
            x.bd = (ed == m_p - 1);
            x.fd = x.bd && (m_j / m_p == m_f - 1);
        end
        return x;
    endfunction

    task automatic drive(input logic st, input logic en, input logic rx,
                         input logic [PW-1:0] pre, input logic [BW-1:0] fb,
                         input exp_t x);
        exp_t y;
        @(negedge clk);
        cnt_start  = st;
        cnt_enable = en;
        rx_in      = rx;
        prescale   = pre;
        frame_bits = fb;
        y          = x;
        tag_ctr++;
        y.tag      = tag_ctr;
        sb_q.push_back(y);
    endtask

    task automatic cnt_cycle(input logic en, input logic rx);
        exp_t x;
        x = model_exp(en);
        drive(1'b0, en, rx, PW'($urandom), BW'($urandom), x);
        if (!m_idle) begin
            if (m_j >= m_p * m_f) begin
                if (!en) m_idle = 1'b1;
            end else if (en) begin
                m_j++;
            end
        end
    endtask

    task automatic start_frame(input int pre, input int fb, input logic en);
        exp_t x;
        x = model_exp(en);
        drive(1'b1, en, 1'b1, PW'(pre), BW'(fb), x);
        m_idle = 1'b0;
        m_j    = 0;
        m_p    = (pre < 4) ? 4 : pre;
        m_f    = (fb < 1) ? 1 : fb;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".edge_count"},    int'(edge_count),    0);
        chk({nm, ".bit_count"},     int'(bit_count),     0);
        chk({nm, ".sample_strobe"}, int'(sample_strobe), 0);
        chk({nm, ".bit_done"},      int'(bit_done),      0);
        chk({nm, ".frame_done"},    int'(frame_done),    0);
        chk({nm, ".busy"},          int'(busy),          0);
    endtask

    // Scoreboard consumer: compares each cycle's expectation before the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sb_q.size() > 0) begin
                mon_x = sb_q.pop_front();
                chk($sformatf("v%0d.edge_count", mon_x.tag),    int'(edge_count),    int'(mon_x.e));
                chk($sformatf("v%0d.bit_count", mon_x.tag),     int'(bit_count),     int'(mon_x.b));
                chk($sformatf("v%0d.sample_strobe", mon_x.tag), int'(sample_strobe), int'(mon_x.s));
                chk($sformatf("v%0d.bit_done", mon_x.tag),      int'(bit_done),      int'(mon_x.bd));
                chk($sformatf("v%0d.frame_done", mon_x.tag),    int'(frame_done),    int'(mon_x.fd));
                chk($sformatf("v%0d.busy", mon_x.tag),          int'(busy),          int'(mon_x.bz));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks, want completion", n_cmp);
        $fatal(1);
    end

    initial begin
        exp_t tx;

        asy_reset  = 1'b0;
        cnt_start  = 1'b0;
        cnt_enable = 1'b0;
        prescale   = '0;
        frame_bits = '0;
        rx_in      = 1'b1;

        // Short frame, P clamps 2->4, F clamps 0->1 (M=2: strobes at 1,2,3).
        //          st    en    pre  fb   edge bit strobe  bd    fd    busy
        tbl[0] = '{1'b1, 1'b0, 6'd2,  4'd0, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 6'd16, 4'd9, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 6'd16, 4'd9, 6'd1, 4'd0, 3'b001, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 6'd16, 4'd9, 6'd2, 4'd0, 3'b010, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 6'd16, 4'd9, 6'd3, 4'd0, 3'b100, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 6'd16, 4'd9, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 6'd16, 4'd9, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 6'd3,  4'd5, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 6'd3,  4'd5, 6'd0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        asy_reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            tx.tag = 0;
            tx.e   = tbl[i].e;
            tx.b   = tbl[i].b;
            tx.s   = tbl[i].s;
            tx.bd  = tbl[i].bd;
            tx.fd  = tbl[i].fd;
            tx.bz  = tbl[i].bz;
            drive(tbl[i].st, tbl[i].en, 1'b1, tbl[i].pre, tbl[i].fb, tx);
        end
        m_idle = 1'b1;

        // P=8, F=10: 80 enabled clocks, then DONE holding bit 9, then IDLE.
        start_frame(8, 10, 1'b0);
        repeat (80) cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b0, 1'b1);
        cnt_cycle(1'b0, 1'b1);

        // P=16, F=11: 176 enabled clocks, bit_count parks at 10.
        start_frame(16, 11, 1'b1);
        repeat (176) cnt_cycle(1'b1, 1'b1);
        repeat (2) cnt_cycle(1'b1, 1'b1);

        // Restart from DONE, then freeze at edge 6 / bit 2 for 5 clocks.
        start_frame(8, 10, 1'b1);
        repeat (22) cnt_cycle(1'b1, 1'b1);
        repeat (5) cnt_cycle(1'b0, 1'b1);
        cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b0, 1'b1);
        cnt_cycle(1'b1, 1'b1);
        repeat (5) cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b0, 1'b1);

        // Async reset mid-frame at edge 5 / bit 3, away from the clock edge.
        @(posedge clk);
        #3;
        asy_reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        m_idle = 1'b1;
        m_j    = 0;
        @(negedge clk);
        asy_reset = 1'b1;

        // Short frame to DONE, then cnt_start in DONE restarts at 0/0.
        start_frame(4, 2, 1'b0);
        repeat (8) cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b1, 1'b1);
        start_frame(8, 3, 1'b1);
        repeat (4) cnt_cycle(1'b1, 1'b1);

        // Start mid-frame, then an RX transition at edge 3 and edge 10.
        start_frame(16, 2, 1'b1);
        repeat (3) cnt_cycle(1'b1, 1'b1);
`ifdef UART_RX_RESYNC_EN
        cnt_cycle(1'b1, 1'b0);
        m_j = 1;
        repeat (9) cnt_cycle(1'b1, 1'b0);
        cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b1, 1'b1);
`else
        cnt_cycle(1'b1, 1'b0);
        repeat (9) cnt_cycle(1'b1, 1'b0);
        cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b1, 1'b1);
`endif
        for (int k = 0; k < 64 && m_j < m_p * m_f; k++) cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b1, 1'b1);
        cnt_cycle(1'b0, 1'b1);
        cnt_cycle(1'b0, 1'b1);

        repeat (2) @(negedge clk);
        #3;
        chk("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
